// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with two combinational read ports and one
// writeback port; each register counts up to 2**CNT_W-1 pending writes.
// Optional macro REGFILE_WB_BYPASS_EN forwards a final writeback to readers.
//
// Ports:
//   clk, rst (async, active low)
//   rs_sel/rs_data/rs_busy  read port A with busy flag
//   rt_sel/rt_data/rt_busy  read port B with busy flag
//   rsv_valid/rsv_sel/rsv_ack  destination reservation at issue
//   wb_valid/wb_sel/wb_data    writeback
//   wb_err                     sticky: writeback with nothing pending
module regfile_scoreboard #(
    parameter int SEL_W   = 2,
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 2,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] rs_sel,
    output logic [WIDTH-1:0] rs_data,
    output logic             rs_busy,
    input  logic [SEL_W-1:0] rt_sel,
    output logic [WIDTH-1:0] rt_data,
    output logic             rt_busy,
    input  logic             rsv_valid,
    input  logic [SEL_W-1:0] rsv_sel,
    output logic             rsv_ack,
    input  logic             wb_valid,
    input  logic [SEL_W-1:0] wb_sel,
    input  logic [WIDTH-1:0] wb_data,
    output logic             wb_err
);

    localparam int NREG = 2 ** SEL_W;
    localparam logic [CNT_W-1:0] MAX_PEND = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [WIDTH-1:0] data_q [NREG];
    logic [CNT_W-1:0] pend_q [NREG];
    logic             wb_err_q;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] wr;
    logic [NREG-1:0] wb_hit;
    logic            rsv_r0;
    logic            wb_r0;
    logic            rsv_room;
    logic            err_set;

    // r0 is hard-wired when ZERO_R0: reserves ack freely, writes vanish
    assign rsv_r0 = ZERO_R0 && (rsv_sel == '0);
    assign wb_r0  = ZERO_R0 && (wb_sel == '0);

    // a same-cycle writeback frees a slot, so a full counter still accepts
    assign rsv_room = (pend_q[rsv_sel] != MAX_PEND)
                   || (wb_valid && (wb_sel == rsv_sel));
    assign rsv_ack  = rsv_valid && (rsv_r0 || rsv_room);

    always_comb begin
        busy   = '0;
        inc    = '0;
        wr     = '0;
        wb_hit = '0;
        for (int i = 0; i < NREG; i++) begin
            busy[i]   = (pend_q[i] != '0);
            inc[i]    = rsv_ack && !rsv_r0
                     && (rsv_sel == SEL_W'(i));
            wb_hit[i] = wb_valid && !wb_r0
                     && (wb_sel == SEL_W'(i));
            // a same-cycle reserve counts first, so an idle
            // register may still take the write
            wr[i]     = wb_hit[i]
                     && ((pend_q[i] != '0) || inc[i]);
        end
    end

    assign err_set = |(wb_hit & ~wr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                pend_q[i] <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr[i]) begin
                    data_q[i] <= wb_data;
                end
                case ({inc[i], wr[i]})
                    2'b10:   pend_q[i] <= pend_q[i] + ONE;
                    2'b01:   pend_q[i] <= pend_q[i] - ONE;
                    default: pend_q[i] <= pend_q[i];
                endcase
            end
            if (err_set) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    assign wb_err = wb_err_q;

`ifdef REGFILE_WB_BYPASS_EN
    logic rs_byp;
    logic rt_byp;

    // forward only the last outstanding write, and not if a
    // new reservation to the same register lands this cycle
    assign rs_byp = wb_valid && !wb_r0 && (wb_sel == rs_sel)
                 && (pend_q[rs_sel] == ONE)
                 && !(rsv_ack && (rsv_sel == rs_sel));
    assign rt_byp = wb_valid && !wb_r0 && (wb_sel == rt_sel)
                 && (pend_q[rt_sel] == ONE)
                 && !(rsv_ack && (rsv_sel == rt_sel));

    assign rs_data = rs_byp ? wb_data : data_q[rs_sel];
    assign rt_data = rt_byp ? wb_data : data_q[rt_sel];
    assign rs_busy = busy[rs_sel] && !rs_byp;
    assign rt_busy = busy[rt_sel] && !rt_byp;
`else
    assign rs_data = data_q[rs_sel];
    assign rt_data = data_q[rt_sel];
    assign rs_busy = busy[rs_sel];
    assign rt_busy = busy[rt_sel];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors for regfile_scoreboard, expected
// outputs queued per cycle and checked by a negedge monitor.
module tb_regfile_scoreboard;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        bit          z;
        logic [31:0] rs_d;
        logic        rs_b;
        logic [31:0] rt_d;
        logic        rt_b;
        logic        ack;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  rs_sel = '0;
    logic [1:0]  rt_sel = '0;
    logic        rsv_valid = 1'b0;
    logic [1:0]  rsv_sel = '0;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_sel = '0;
    logic [31:0] wb_data = '0;

    logic [31:0] a_rs_data, a_rt_data;
    logic        a_rs_busy, a_rt_busy, a_ack, a_err;
    logic [31:0] b_rs_data, b_rt_data;
    logic        b_rs_busy, b_rt_busy, b_ack, b_err;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sbq[$];
    exp_t e;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .SEL_W(2), .WIDTH(32), .CNT_W(2), .ZERO_R0(1'b0)
    ) u_a (
        .clk(clk), .rst(rst),
        .rs_sel(rs_sel), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
        .rt_sel(rt_sel), .rt_data(a_rt_data), .rt_busy(a_rt_busy),
        .rsv_valid(rsv_valid), .rsv_sel(rsv_sel), .rsv_ack(a_ack),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
        .wb_err(a_err)
    );

    regfile_scoreboard #(
        .SEL_W(2), .WIDTH(32), .CNT_W(2), .ZERO_R0(1'b1)
    ) u_b (
        .clk(clk), .rst(rst),
        .rs_sel(rs_sel), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
        .rt_sel(rt_sel), .rt_data(b_rt_data), .rt_busy(b_rt_busy),
        .rsv_valid(rsv_valid), .rsv_sel(rsv_sel), .rsv_ack(b_ack),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
        .wb_err(b_err)
    );

    // monitor: pops every expectation issued for this cycle
    always @(negedge clk) begin
        logic [31:0] rsd, rtd;
        logic        rsb, rtb, ack, err;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rsd = e.z ? b_rs_data : a_rs_data;
            rsb = e.z ? b_rs_busy : a_rs_busy;
            rtd = e.z ? b_rt_data : a_rt_data;
            rtb = e.z ? b_rt_busy : a_rt_busy;
            ack = e.z ? b_ack : a_ack;
            err = e.z ? b_err : a_err;
            n_cmp++;
            if (rsd !== e.rs_d || rsb !== e.rs_b
                || rtd !== e.rt_d || rtb !== e.rt_b
                || ack !== e.ack || err !== e.err) begin
                n_bad++;
                $display("FAIL %s: got rs=%h/%b rt=%h/%b ack=%b err=%b want rs=%h/%b rt=%h/%b ack=%b err=%b",
                         e.name, rsd, rsb, rtd, rtb, ack, err,
                         e.rs_d, e.rs_b, e.rt_d, e.rt_b,
                         e.ack, e.err);
            end
        end
    end

    task automatic step(
        input string       nm,
        input bit          z,
        input int          rss,
        input int          rts,
        input bit          rv,
        input int          rsl,
        input bit          wv,
        input int          wsl,
        input logic [31:0] wd,
        input bit          pulse,
        input logic [31:0] ers,
        input bit          erb,
        input logic [31:0] ert,
        input bit          etb,
        input bit          eack,
        input bit          eerr
    );
        exp_t x;
        rs_sel    = 2'(rss);
        rt_sel    = 2'(rts);
        rsv_valid = rv;
        rsv_sel   = 2'(rsl);
        wb_valid  = wv;
        wb_sel    = 2'(wsl);
        wb_data   = wd;
        if (pulse) begin
            #2 rst = 1'b0;
            #1 rst = 1'b1;
        end
        x.name = nm;
        x.z    = z;
        x.rs_d = ers;
        x.rs_b = erb;
        x.rt_d = ert;
        x.rt_b = etb;
        x.ack  = eack;
        x.err  = eerr;
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        localparam logic [31:0] DB = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        // held in reset
        step("rst_a", 0, 0, 3, 1, 2, 1, 2, 5, 0, 0, 0, 0, 0, 1, 0);
        step("rst_b", 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        // single reservation then writeback
        step("rsv_r2", 0, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("busy_r2", 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("wb_r2", 0, 2, 2, 0, 0, 1, 2, DB, 0,
             BYP ? DB : 0, !BYP, BYP ? DB : 0, !BYP, 0, 0);
        step("rd_r2", 0, 2, 1, 0, 0, 0, 0, 0, 0, DB, 0, 0, 0, 0, 0);
        // same-cycle reserve + writeback on idle register
        step("rw_r0", 0, 0, 2, 1, 0, 1, 0, 32'h77, 0,
             0, 0, DB, 0, 1, 0);
        step("rd_r0", 0, 0, 0, 0, 0, 0, 0, 0, 0,
             32'h77, 0, 32'h77, 0, 0, 0);
        // fill r1 to MAX_PEND
        step("rsv1_1", 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, DB, 0, 1, 0);
        step("rsv1_2", 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, DB, 0, 1, 0);
        step("rsv1_3", 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, DB, 0, 1, 0);
        step("rsv1_full", 0, 1, 2, 1, 1, 0, 0, 0, 0,
             0, 1, DB, 0, 0, 0);
        step("rsv1_wb", 0, 1, 1, 1, 1, 1, 1, 32'h11, 0,
             0, 1, 0, 1, 1, 0);
        step("still_full", 0, 1, 1, 1, 1, 0, 0, 0, 0,
             32'h11, 1, 32'h11, 1, 0, 0);
        step("wb1_a", 0, 1, 1, 0, 0, 1, 1, 32'h22, 0,
             32'h11, 1, 32'h11, 1, 0, 0);
        step("wb1_b", 0, 1, 1, 0, 0, 1, 1, 32'h33, 0,
             32'h22, 1, 32'h22, 1, 0, 0);
        step("wb1_c", 0, 1, 1, 0, 0, 1, 1, 32'h44, 0,
             BYP ? 32'h44 : 32'h33, !BYP,
             BYP ? 32'h44 : 32'h33, !BYP, 0, 0);
        step("r1_free", 0, 1, 1, 0, 0, 0, 0, 0, 0,
             32'h44, 0, 32'h44, 0, 0, 0);
        // writeback with nothing pending
        step("wb_r3_err", 0, 3, 1, 0, 0, 1, 3, 32'h1234, 0,
             0, 0, 32'h44, 0, 0, 0);
        step("err_set", 0, 3, 1, 0, 0, 0, 0, 0, 0,
             0, 0, 32'h44, 0, 0, 1);
        step("rsv_r0", 0, 0, 3, 1, 0, 0, 0, 0, 0,
             32'h77, 0, 0, 0, 1, 1);
        step("busy_r0", 0, 0, 3, 0, 0, 0, 0, 0, 0,
             32'h77, 1, 0, 0, 0, 1);
        // reset pulse between edges
        step("mid_rst", 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("late_wb", 0, 0, 2, 0, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        step("late_err", 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // bypass with one and two pending
        step("byp_rsv", 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("byp_wb", 0, 0, 1, 0, 0, 1, 1, 32'h55, 0,
             0, 0, BYP ? 32'h55 : 0, !BYP, 0, 1);
        step("byp_rd", 0, 0, 1, 0, 0, 0, 0, 0, 0,
             0, 0, 32'h55, 0, 0, 1);
        step("p2_rsv_a", 0, 0, 1, 1, 1, 0, 0, 0, 0,
             0, 0, 32'h55, 0, 1, 1);
        step("p2_rsv_b", 0, 0, 1, 1, 1, 0, 0, 0, 0,
             0, 0, 32'h55, 1, 1, 1);
        step("p2_wb", 0, 0, 1, 0, 0, 1, 1, 32'h66, 0,
             0, 0, 32'h55, 1, 0, 1);
        step("p1_rd", 0, 0, 1, 0, 0, 0, 0, 0, 0,
             0, 0, 32'h66, 1, 0, 1);
        step("p1_wb", 0, 0, 1, 0, 0, 1, 1, 32'h77, 0,
             0, 0, BYP ? 32'h77 : 32'h66, !BYP, 0, 1);
        step("p0_rd", 0, 0, 1, 0, 0, 0, 0, 0, 0,
             0, 0, 32'h77, 0, 0, 1);
        // hard-wired r0 instance
        step("z_rst", 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        step("z_rw", 1, 0, 0, 1, 0, 1, 0, 32'hFF, 0,
             0, 0, 0, 0, 1, 0);
        step("z_wb", 1, 0, 0, 0, 0, 1, 0, 32'hFF, 0,
             0, 0, 0, 0, 0, 0);
        step("z_rd", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("z_rsv2", 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("z_busy2", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with a per-register write-reservation scoreboard, the successor to the single-pending-bit register file used between instruction decode and execute. It provides two combinational read ports with busy flags and one writeback port. Destinations are reserved at issue, and each register tracks up to `MAX_PEND` outstanding writes instead of one. Decode uses `rs_busy` and `rt_busy` to raise its stall, and `rsv_ack` to decide whether an instruction may issue.

## Interface
- `SEL_W`, 2: register select width; `NREG = 2**SEL_W` registers.
- `WIDTH`, 32: data width.
- `CNT_W`, 2: pending-counter width; `MAX_PEND = 2**CNT_W - 1`.
- `ZERO_R0`, 0: when 1, r0 reads 0, is never busy, and ignores reservations and writes.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rs_sel`  in  SEL_W  read port A select.
- `rs_data`  out  WIDTH  read port A data (combinational).
- `rs_busy`  out  1  register A has a pending write.
- `rt_sel`  in  SEL_W  read port B select.
- `rt_data`  out  WIDTH  read port B data.
- `rt_busy`  out  1  register B has a pending write.
- `rsv_valid`  in  1  reserve request for `rsv_sel`.
- `rsv_sel`  in  SEL_W  destination to reserve.
- `rsv_ack`  out  1  reservation accepted this cycle (combinational).
- `wb_valid`  in  1  writeback strobe.
- `wb_sel`  in  SEL_W  writeback destination.
- `wb_data`  in  WIDTH  writeback data.
- `wb_err`  out  1  sticky: a writeback hit a register with zero pending writes.

## Operation
- State: `data[NREG]` (WIDTH each), `pend[NREG]` (CNT_W each), `wb_err`.
- Busy: `busy[i] = (pend[i] != 0)`. `rs_busy = busy[rs_sel]` and `rt_busy = busy[rt_sel]`. With `ZERO_R0`, busy for r0 is forced to 0.
- `rsv_ack = rsv_valid & (pend[rsv_sel] != MAX_PEND)`.
  - A simultaneous writeback to the same register counts as freeing one slot, so the ack is 1 even at `MAX_PEND` in that case.
- Counter update per register `i`, with `inc = rsv_ack & rsv_sel==i` and `dec = wb_valid & wb_sel==i & pend[i]!=0`:
  - inc only: `pend + 1`.
  - dec only: `pend - 1`.
  - both: `pend` unchanged.
  - Counters never wrap.
- Data: on `wb_valid` with `pend[wb_sel] != 0`, `data[wb_sel] <= wb_data`.
  - Writeback to a register with `pend == 0` (and no same-cycle reserve): data is not written and `wb_err <= 1`.
  - `wb_err` holds 1 until reset.
- Writebacks complete in issue order per register. Data is always last-written; no per-tag tracking.
- Reserve and writeback to the same register with `pend == 0` in the same cycle: the reservation is counted first, so data is written, `pend` stays 0, and no error is raised.
- `ZERO_R0=1`: `rsv_ack` for r0 is 1 whenever `rsv_valid`, with no counter change. Writes to r0 are dropped with no error.

## Timing
- Reset (`rst`=0, asynchronous): all `data` = 0, all `pend` = 0, `wb_err` = 0. Outputs are then `rs_data`=`rt_data`=0, busy flags 0, `rsv_ack`=`rsv_valid`.
- Reads are zero-latency combinational from current state. A write is visible on read ports the cycle after the `wb_valid` edge, unless the bypass below is enabled.
- A reservation makes busy assert the cycle after the accepting edge.
- Reset asserted mid-operation discards all pending reservations immediately. Writebacks arriving after reset release are then flagged by `wb_err`.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined: for each read port, if `wb_valid & wb_sel==sel & pend[sel]==1` and there is no same-cycle accepted reserve to `sel`, then:
  - data output = `wb_data`;
  - busy output = 0.
  - This saves one stall cycle.
- Undefined: no bypass. Reads reflect registered state only, and busy stays 1 through the writeback cycle.

## Test plan
- Reset then read all registers: `rs_data`=`rt_data`=0, busy=0, `wb_err`=0; `rst` pulsed low mid-cycle clears state without a clock edge.
- Reserve r2, next cycle `rs_sel`=2: `rs_busy`=1. Writeback r2=0xDEADBEEF: next cycle `rs_data`=0xDEADBEEF, `rs_busy`=0.
- `CNT_W`=2:
  - reserve r1 three times, all acked;
  - fourth reserve gives `rsv_ack`=0;
  - same cycle as writeback r1 gives `rsv_ack`=1 with `pend` staying 3;
  - three further writebacks clear busy.
- Writeback r3=0x1234 with no reservation: r3 stays 0 and `wb_err`=1 from the next cycle until reset.
- With `REGFILE_WB_BYPASS_EN`:
  - reserve r1 once, then writeback r1=0x55 with `rt_sel`=1 gives `rt_data`=0x55, `rt_busy`=0 in the same cycle;
  - with `pend`=2, `rt_busy` stays 1.
- `ZERO_R0`=1: reserve and writeback r0=0xFF; r0 reads 0, never busy, `wb_err` stays 0.
